character_controller: RTL and testbench
=======================================

CHARACTER_CONTROLLER -- requirements
Module: character_controller

Interface
REQ-001 Parameter TILE_PX, default 16, pixels per tile step; SHALL be a power of two, 4..32.
REQ-002 Parameter MAP_W, default 32, map width in tiles.
REQ-003 Parameter MAP_H, default 32, map height in tiles.
REQ-004 Parameter TURN_TICKS, default 4, frame ticks spent turning in place.
REQ-005 Parameter START_X / START_Y, default 16 / 16, reset tile position.
REQ-006 Clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 frame_tick  input  1  one-Clk pulse per video frame (vsync edge); all motion advances only on ticks.
REQ-009 keycode  input  8  current USB HID keycode: 0x1A W, 0x04 A, 0x16 S, 0x07 D; any other value means no key.
REQ-010 Direction  output  2  facing: 0 down, 1 up, 2 left, 3 right.
REQ-011 Character_Moving  output  1  high while in WALK.
REQ-012 Walk_Frame  output  2  animation frame index for the sprite mapper.
REQ-013 Tile_X / Tile_Y  output  8 / 8  current tile coordinates, updated at step completion.
REQ-014 Step_Offset  output  5  pixels travelled within the current step, 0..TILE_PX-1.

Function
REQ-015 The FSM SHALL have states IDLE, TURN and WALK; state and outputs SHALL change only on Clk edges with frame_tick=1, except under Reset.
REQ-016 IDLE, valid key, key direction != Direction: SHALL load Direction, clear the turn counter, go to TURN.
REQ-017 IDLE, valid key, key direction == Direction, target tile in map: SHALL go to WALK with Step_Offset=0.
REQ-018 IDLE, valid key == Direction, target tile outside 0..MAP_W-1 / 0..MAP_H-1: SHALL stay IDLE, position unchanged (blocked step).
REQ-019 TURN: SHALL count TURN_TICKS ticks; then go to WALK if the same key is still held and the target is in map, else to IDLE.
REQ-020 A key change during TURN SHALL be ignored until TURN ends.
REQ-021 WALK: Step_Offset SHALL increase by the step rate per tick; keycode SHALL be ignored until the step completes.
REQ-022 Step completion, when Step_Offset + rate reaches TILE_PX: SHALL update Tile_X/Tile_Y by +/-1 per Direction and reset Step_Offset to 0. It SHALL then re-evaluate the key in the same tick using the REQ-016..018 rules, so a held key walks continuously with no idle tick.
REQ-023 Walk_Frame SHALL increment, wrapping 3->0, at Step_Offset = TILE_PX/2 and at step completion. It SHALL hold its value in IDLE and TURN.
REQ-024 Character_Moving SHALL be 1 exactly while in WALK.
REQ-025 Tile arithmetic SHALL never wrap: coordinates stay within 0..MAP_W-1 and 0..MAP_H-1.

Reset
REQ-026 On Reset: state IDLE, Direction=0 (down), Character_Moving=0, Walk_Frame=0, Step_Offset=0, Tile_X=START_X, Tile_Y=START_Y.
REQ-027 Reset asserted mid-step SHALL abandon the step; the partial offset is not committed.
REQ-028 Reset SHALL take priority over frame_tick in the same cycle.

Configuration
REQ-029 Macro CHARACTER_RUN_EN defined: add input Run_Key (1 bit), sampled at step start. If high, the step rate for that whole step SHALL be 2 px/tick; otherwise 1.
REQ-030 Macro CHARACTER_RUN_EN undefined: Run_Key SHALL be absent and the step rate SHALL always be 1 px/tick.

Structure
REQ-031 Shared package game_pkg SHALL hold the direction enum (DIR_DOWN..DIR_RIGHT), the keycode constants, and the FSM state typedef.
REQ-032 One sub-module, key_decoder, SHALL be used: it maps keycode to {valid, direction}, combinationally.

Verification
REQ-033 Reset, then hold keycode 0x07 (D) with ticks: Direction=3 after 1 tick; WALK after 4 more ticks; Tile_X=17 and Step_Offset=0 after 16 more ticks.
REQ-034 At reset, hold 0x16 (S, already facing down): no TURN; continuous steps; Tile_Y = 17, 18, 19 at ticks 16, 32, 48; Character_Moving stays 1.
REQ-035 Tile_X=0, facing left, press 0x04 (A): stays IDLE, Tile_X=0, Character_Moving=0.
REQ-036 Release key at Step_Offset=5: walk continues to Step_Offset=0 with tile updated, then IDLE; Walk_Frame advances exactly twice.
REQ-037 Assert Reset at Step_Offset=9: next cycle all outputs equal REQ-026 values.
REQ-038 With CHARACTER_RUN_EN and Run_Key=1 at step start: step completes in 8 ticks; Run_Key dropped mid-step does not change the rate.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the character controller: facing directions, HID keycodes, FSM states.
package game_pkg;
  typedef enum logic [1:0] {DIR_DOWN = 2'd0, DIR_UP = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_TURN = 2'd1, ST_WALK = 2'd2} state_e;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;
endpackage

// File: rtl/character_controller_if.sv
// Frame/key inputs and sprite state outputs of the character controller.
// CHARACTER_RUN_EN adds the Run_Key input.
interface character_controller_if;
  logic       frame_tick;
  logic [7:0] keycode;
  logic [1:0] Direction;
  logic       Character_Moving;
  logic [1:0] Walk_Frame;
  logic [7:0] Tile_X;
  logic [7:0] Tile_Y;
  logic [4:0] Step_Offset;
`ifdef CHARACTER_RUN_EN
  logic       Run_Key;
  modport slave  (input frame_tick, keycode, Run_Key,
                  output Direction, Character_Moving, Walk_Frame, Tile_X, Tile_Y, Step_Offset);
  modport master (output frame_tick, keycode, Run_Key,
                  input Direction, Character_Moving, Walk_Frame, Tile_X, Tile_Y, Step_Offset);
`else
  modport slave  (input frame_tick, keycode,
                  output Direction, Character_Moving, Walk_Frame, Tile_X, Tile_Y, Step_Offset);
  modport master (output frame_tick, keycode,
                  input Direction, Character_Moving, Walk_Frame, Tile_X, Tile_Y, Step_Offset);
`endif
endinterface

// File: rtl/key_decoder.sv
// Maps a HID keycode to {valid, direction}; purely combinational.
module key_decoder
  import game_pkg::*;
(
  input  logic [7:0] i_keycode,
  output logic       o_valid,
  output dir_e       o_dir
);
  always_comb begin
    o_valid = 1'b1;
    o_dir   = DIR_DOWN;
    case (i_keycode)
      KEY_S:   o_dir = DIR_DOWN;
      KEY_W:   o_dir = DIR_UP;
      KEY_A:   o_dir = DIR_LEFT;
      KEY_D:   o_dir = DIR_RIGHT;
      default: o_valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/character_controller.sv
// Tile-stepping character FSM (IDLE/TURN/WALK) advancing on frame ticks.
// CHARACTER_RUN_EN enables Run_Key: 2 px/tick for a step started with it held.
module character_controller
  import game_pkg::*;
#(
  parameter int TILE_PX    = 16,
  parameter int MAP_W      = 32,
  parameter int MAP_H      = 32,
  parameter int TURN_TICKS = 4,
  parameter int START_X    = 16,
  parameter int START_Y    = 16
) (
  input logic                   Clk,
  input logic                   Reset,
  character_controller_if.slave bus
);
  localparam int TCW = (TURN_TICKS > 1) ? $clog2(TURN_TICKS) : 1;

  state_e           r_state;
  dir_e             r_dir;
  logic             r_moving;
  logic [1:0]       r_wf;
  logic [4:0]       r_off;
  logic [7:0]       r_tx, r_ty;
  logic [TCW-1:0]   r_turn_cnt;

  logic       w_key_vld;
  dir_e       w_key_dir;
  logic [5:0] w_rate, w_off_sum;
  logic       w_done;
  logic [7:0] w_nx, w_ny;
  logic       w_ok_here, w_ok_next;

  key_decoder u_key (.i_keycode(bus.keycode), .o_valid(w_key_vld), .o_dir(w_key_dir));

  function automatic logic in_map(dir_e d, logic [7:0] x, logic [7:0] y);
    case (d)
      DIR_DOWN:  in_map = int'(y) < MAP_H - 1;
      DIR_UP:    in_map = y != 8'd0;
      DIR_LEFT:  in_map = x != 8'd0;
      default:   in_map = int'(x) < MAP_W - 1;
    endcase
  endfunction

  function automatic logic [15:0] step_xy(dir_e d, logic [7:0] x, logic [7:0] y);
    case (d)
      DIR_DOWN:  step_xy = {x, y + 8'd1};
      DIR_UP:    step_xy = {x, y - 8'd1};
      DIR_LEFT:  step_xy = {x - 8'd1, y};
      default:   step_xy = {x + 8'd1, y};
    endcase
  endfunction

`ifdef CHARACTER_RUN_EN
  logic r_run;
  // Re-sampled on every tick outside a step; frozen for the rest of the step once WALK starts.
  always_ff @(posedge Clk) begin
    if (Reset)                                                   r_run <= 1'b0;
    else if (bus.frame_tick && (r_state != ST_WALK || w_done))   r_run <= bus.Run_Key;
  end
  assign w_rate = r_run ? 6'd2 : 6'd1;
`else
  assign w_rate = 6'd1;
`endif

  assign w_off_sum      = {1'b0, r_off} + w_rate;
  assign w_done         = w_off_sum >= 6'(TILE_PX);
  assign {w_nx, w_ny}   = step_xy(r_dir, r_tx, r_ty);
  assign w_ok_here      = in_map(w_key_dir, r_tx, r_ty);
  assign w_ok_next      = in_map(w_key_dir, w_nx, w_ny);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_dir      <= DIR_DOWN;
      r_moving   <= 1'b0;
      r_wf       <= 2'd0;
      r_off      <= 5'd0;
      r_tx       <= 8'(START_X);
      r_ty       <= 8'(START_Y);
      r_turn_cnt <= '0;
    end else if (bus.frame_tick) begin
      case (r_state)
        ST_IDLE: if (w_key_vld) begin
          if (w_key_dir != r_dir) begin
            r_dir      <= w_key_dir;
            r_turn_cnt <= '0;
            r_state    <= ST_TURN;
          end else if (w_ok_here) begin
            r_state  <= ST_WALK;
            r_moving <= 1'b1;
            r_off    <= 5'd0;
          end
        end
        ST_TURN: if (r_turn_cnt == TCW'(TURN_TICKS - 1)) begin
          if (w_key_vld && w_key_dir == r_dir && w_ok_here) begin
            r_state  <= ST_WALK;
            r_moving <= 1'b1;
            r_off    <= 5'd0;
          end else begin
            r_state  <= ST_IDLE;
          end
        end else begin
          r_turn_cnt <= r_turn_cnt + TCW'(1);
        end
        ST_WALK: if (w_done) begin
          r_tx  <= w_nx;
          r_ty  <= w_ny;
          r_off <= 5'd0;
          r_wf  <= r_wf + 2'd1;
          // Key is re-evaluated from the new tile so a held key chains steps with no idle tick.
          if (w_key_vld && w_key_dir != r_dir) begin
            r_dir      <= w_key_dir;
            r_turn_cnt <= '0;
            r_state    <= ST_TURN;
            r_moving   <= 1'b0;
          end else if (!(w_key_vld && w_ok_next)) begin
            r_state  <= ST_IDLE;
            r_moving <= 1'b0;
          end
        end else begin
          r_off <= w_off_sum[4:0];
          if (w_off_sum == 6'(TILE_PX / 2)) r_wf <= r_wf + 2'd1;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Direction        = r_dir;
  assign bus.Character_Moving = r_moving;
  assign bus.Walk_Frame       = r_wf;
  assign bus.Tile_X           = r_tx;
  assign bus.Tile_Y           = r_ty;
  assign bus.Step_Offset      = r_off;
endmodule

// File: tb/tb_character_controller.sv
// Directed bench for character_controller: vector table plus hand-written multi-tick sequences.
module tb_character_controller;
  logic Clk = 1'b0;
  logic Reset;
  character_controller_if bus();

  character_controller dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] key;
    int         n;
    logic [1:0] dir;
    logic       mov;
    logic [7:0] tx, ty;
    logic [4:0] off;
    logic [1:0] wf;
  } vec_t;

  vec_t vecs[16];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic vec_t mk(logic [7:0] key, int n, logic [1:0] dir, logic mov,
                              logic [7:0] tx, logic [7:0] ty, logic [4:0] off, logic [1:0] wf);
    vec_t v;
    v.key = key; v.n = n; v.dir = dir; v.mov = mov;
    v.tx = tx; v.ty = ty; v.off = off; v.wf = wf;
    return v;
  endfunction

  function automatic logic [25:0] pack(logic [1:0] dir, logic mov, logic [7:0] tx, logic [7:0] ty,
                                       logic [4:0] off, logic [1:0] wf);
    return {dir, mov, tx, ty, off, wf};
  endfunction

  function automatic logic [25:0] actual();
    return pack(bus.Direction, bus.Character_Moving, bus.Tile_X, bus.Tile_Y,
                bus.Step_Offset, bus.Walk_Frame);
  endfunction

  // Fields: dir mov tx ty off wf
  task automatic chk(string name, logic [25:0] act, logic [25:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got dir=%0d mov=%0d x=%0d y=%0d off=%0d wf=%0d, want dir=%0d mov=%0d x=%0d y=%0d off=%0d wf=%0d",
               name, act[25:24], act[23], act[22:15], act[14:7], act[6:2], act[1:0],
               exp[25:24], exp[23], exp[22:15], exp[14:7], exp[6:2], exp[1:0]);
    end
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      @(posedge Clk); #1;
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic do_reset(logic with_tick);
    Reset = 1'b1;
    bus.frame_tick = with_tick;
    @(posedge Clk); #1;
    Reset = 1'b0;
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    logic [25:0] rst_exp;
    logic        mov_ok;
    rst_exp = pack(2'd0, 1'b0, 8'd16, 8'd16, 5'd0, 2'd0);
    Reset = 1'b1;
    bus.frame_tick = 1'b0;
    bus.keycode = 8'h00;
`ifdef CHARACTER_RUN_EN
    bus.Run_Key = 1'b0;
`endif

    vecs[0]  = mk(8'h07,  1, 2'd3, 1'b0, 8'd16, 8'd16, 5'd0,  2'd0);
    vecs[1]  = mk(8'h07,  3, 2'd3, 1'b0, 8'd16, 8'd16, 5'd0,  2'd0);
    vecs[2]  = mk(8'h07,  1, 2'd3, 1'b1, 8'd16, 8'd16, 5'd0,  2'd0);
    vecs[3]  = mk(8'h07,  8, 2'd3, 1'b1, 8'd16, 8'd16, 5'd8,  2'd1);
    vecs[4]  = mk(8'h07,  7, 2'd3, 1'b1, 8'd16, 8'd16, 5'd15, 2'd1);
    vecs[5]  = mk(8'h07,  1, 2'd3, 1'b1, 8'd17, 8'd16, 5'd0,  2'd2);
    vecs[6]  = mk(8'h00,  5, 2'd3, 1'b1, 8'd17, 8'd16, 5'd5,  2'd2);
    vecs[7]  = mk(8'h00,  3, 2'd3, 1'b1, 8'd17, 8'd16, 5'd8,  2'd3);
    vecs[8]  = mk(8'h00,  8, 2'd3, 1'b0, 8'd18, 8'd16, 5'd0,  2'd0);
    vecs[9]  = mk(8'h55,  2, 2'd3, 1'b0, 8'd18, 8'd16, 5'd0,  2'd0);
    vecs[10] = mk(8'h1A,  1, 2'd1, 1'b0, 8'd18, 8'd16, 5'd0,  2'd0);
    vecs[11] = mk(8'h16,  4, 2'd1, 1'b0, 8'd18, 8'd16, 5'd0,  2'd0);
    vecs[12] = mk(8'h1A,  1, 2'd1, 1'b1, 8'd18, 8'd16, 5'd0,  2'd0);
    vecs[13] = mk(8'h1A, 16, 2'd1, 1'b1, 8'd18, 8'd15, 5'd0,  2'd2);
    vecs[14] = mk(8'h04, 16, 2'd2, 1'b0, 8'd18, 8'd14, 5'd0,  2'd0);
    vecs[15] = mk(8'h04,  5, 2'd2, 1'b1, 8'd18, 8'd14, 5'd1,  2'd0);

    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    chk("reset_state", actual(), rst_exp);

    for (int i = 0; i < 16; i++) begin
      bus.keycode = vecs[i].key;
      ticks(vecs[i].n);
      chk($sformatf("vec%0d", i), actual(),
          pack(vecs[i].dir, vecs[i].mov, vecs[i].tx, vecs[i].ty, vecs[i].off, vecs[i].wf));
    end

    // Mid-step abandon by reset, with a tick in the same cycle; no-tick cycles must hold state.
    bus.keycode = 8'h00;
    do_reset(1'b0);
    bus.keycode = 8'h16;
    ticks(10);
    chk("walk_off9", actual(), pack(2'd0, 1'b1, 8'd16, 8'd16, 5'd9, 2'd1));
    repeat (5) @(posedge Clk);
    #1;
    chk("no_tick_hold", actual(), pack(2'd0, 1'b1, 8'd16, 8'd16, 5'd9, 2'd1));
    do_reset(1'b1);
    chk("reset_mid_step", actual(), rst_exp);

    // Held S from reset: continuous steps without TURN.
    ticks(1);
    mov_ok = bus.Character_Moving;
    for (int t = 1; t <= 48; t++) begin
      ticks(1);
      if (bus.Character_Moving !== 1'b1) mov_ok = 1'b0;
      if (t % 16 == 0)
        chk($sformatf("cont_walk_t%0d", t), actual(),
            pack(2'd0, 1'b1, 8'd16, 8'(16 + t / 16), 5'd0, 2'((t / 16) * 2)));
    end
    n_checks++;
    if (mov_ok !== 1'b1) begin
      n_err++;
      $display("FAIL cont_walk_moving: got a tick with Character_Moving=0, want 1 throughout");
    end

    // Walk left to the map edge; further presses are blocked.
    bus.keycode = 8'h00;
    do_reset(1'b0);
    bus.keycode = 8'h04;
    ticks(280);
    chk("left_edge", actual(), pack(2'd2, 1'b0, 8'd0, 8'd16, 5'd0, 2'd0));
    bus.keycode = 8'h00;
    ticks(2);
    bus.keycode = 8'h04;
    ticks(5);
    chk("left_edge_blocked", actual(), pack(2'd2, 1'b0, 8'd0, 8'd16, 5'd0, 2'd0));

`ifdef CHARACTER_RUN_EN
    bus.keycode = 8'h00;
    do_reset(1'b0);
    bus.keycode = 8'h16;
    bus.Run_Key = 1'b1;
    ticks(1);
    bus.Run_Key = 1'b0;
    ticks(4);
    chk("run_half", actual(), pack(2'd0, 1'b1, 8'd16, 8'd16, 5'd8, 2'd1));
    ticks(4);
    chk("run_done8", actual(), pack(2'd0, 1'b1, 8'd16, 8'd17, 5'd0, 2'd2));
    ticks(1);
    chk("run_next_walk", actual(), pack(2'd0, 1'b1, 8'd16, 8'd17, 5'd1, 2'd2));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
